// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the ALU and load-unit result streams into one
// register-file write port through a DEPTH-entry circular FIFO.
// The load unit has priority when both offer in the same cycle. Writes to
// register 0 are accepted and then dropped. Pending reports every register
// with a write queued or currently being driven.
// Optional feature: define WB_BYPASS_EN to let an offer that arrives while the
// queue is empty go straight to the output registers (latency 1 instead of 2).
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        ResetN,
    input  logic        AluValid,
    input  logic [4:0]  AluRegister,
    input  logic [31:0] AluData,
    output logic        AluReady,
    input  logic        MemValid,
    input  logic [4:0]  MemRegister,
    input  logic [31:0] MemData,
    output logic        MemReady,
    output logic        WriteEnable,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic [31:0] Pending,
    output logic        Full,
    output logic        Empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [4:0]       q_reg  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        accept;
    logic        keep;
    logic        pop;
    logic        push;
    logic        bypass;

    // Occupancy flags come from the count before the edge; readies are
    // forced low while reset is held so nothing is accepted during reset.
    assign Full     = (count == CNT_W'(DEPTH));
    assign Empty    = (count == '0);
    assign MemReady = ResetN && !Full;
    assign AluReady = ResetN && !Full && !MemValid;

    // Select the winning offer and decide whether it is queued, bypassed or dropped.
    always_comb begin
        in_reg  = MemValid ? MemRegister : AluRegister;
        in_data = MemValid ? MemData : AluData;
        accept  = (MemValid && MemReady) || (AluValid && AluReady);
        keep    = accept && (in_reg != 5'd0);
        pop     = !Empty;
        bypass  = BYPASS && keep && Empty;
        push    = keep && !bypass;
    end

    // Queue payload storage; validity is tracked by head/count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[tail]  <= in_reg;
            q_data[tail] <= in_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Output register: drive the popped head, or the bypassed offer, for one cycle.
    always_ff @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            WriteEnable   <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= 32'd0;
        end else if (pop) begin
            WriteEnable   <= 1'b1;
            WriteRegister <= q_reg[head];
            WriteData     <= q_data[head];
        end else if (bypass) begin
            WriteEnable   <= 1'b1;
            WriteRegister <= in_reg;
            WriteData     <= in_data;
        end else begin
            WriteEnable   <= 1'b0;
        end
    end

    // Pending scoreboard: OR of every live queue entry plus the active write.
    always_comb begin
        Pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count)
                Pending[q_reg[head + PTR_W'(k)]] = 1'b1;
        end
        if (WriteEnable)
            Pending[WriteRegister] = 1'b1;
        Pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam int EXP_LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int EXP_LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        AluValid = 1'b0;
    logic [4:0]  AluRegister = '0;
    logic [31:0] AluData = '0;
    logic        AluReady;
    logic        MemValid = 1'b0;
    logic [4:0]  MemRegister = '0;
    logic [31:0] MemData = '0;
    logic        MemReady;
    logic        WriteEnable;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] Pending;
    logic        Full;
    logic        Empty;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .ResetN(ResetN),
        .AluValid(AluValid), .AluRegister(AluRegister), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemRegister(MemRegister), .MemData(MemData), .MemReady(MemReady),
        .WriteEnable(WriteEnable), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .Pending(Pending), .Full(Full), .Empty(Empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit model_on = 1'b0;
    bit pend_seen = 1'b0;

    typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
    typedef struct { logic [4:0] r; logic [31:0] d; int c; bit p; } wlog_t;

    ent_t  mq[$];
    logic  m_we = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;
    wlog_t wlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) p[mq[i].r] = 1'b1;
        if (m_we) p[m_wr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a plain queue of accepted nonzero writes.
    always @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            mq.delete();
            m_we = 1'b0;
            m_wr = '0;
            m_wd = '0;
        end else begin
            bit   full, acc;
            ent_t e;
            full = (mq.size() == DEPTH);
            acc = 1'b0;
            e = '0;
            if (MemValid && !full) begin
                acc = 1'b1; e.r = MemRegister; e.d = MemData;
            end else if (AluValid && !full && !MemValid) begin
                acc = 1'b1; e.r = AluRegister; e.d = AluData;
            end
            if (mq.size() > 0) begin
                ent_t h;
                h = mq.pop_front();
                m_we = 1'b1; m_wr = h.r; m_wd = h.d;
                if (acc && e.r != 0) mq.push_back(e);
            end else if (acc && e.r != 0 && BYP) begin
                m_we = 1'b1; m_wr = e.r; m_wd = e.d;
            end else begin
                m_we = 1'b0;
                if (acc && e.r != 0) mq.push_back(e);
            end
        end
    end

    // Per-cycle comparison against the model, plus write log collection.
    always @(negedge clk) begin
        if (WriteEnable) begin
            wlog_t w;
            w.r = WriteRegister; w.d = WriteData; w.c = cyc; w.p = Pending[WriteRegister];
            wlog.push_back(w);
        end
        if (Pending != 0) pend_seen = 1'b1;
        if (model_on) begin
            chk("MemReady", {31'd0, MemReady}, {31'd0, ResetN && mq.size() != DEPTH});
            chk("AluReady", {31'd0, AluReady}, {31'd0, ResetN && mq.size() != DEPTH && !MemValid});
            chk("WriteEnable", {31'd0, WriteEnable}, {31'd0, m_we});
            if (m_we || !ResetN) begin
                chk("WriteRegister", {27'd0, WriteRegister}, {27'd0, m_wr});
                chk("WriteData", WriteData, m_wd);
            end
            chk("Pending", Pending, model_pending());
            chk("Full", {31'd0, Full}, {31'd0, mq.size() == DEPTH});
            chk("Empty", {31'd0, Empty}, {31'd0, mq.size() == 0});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit is_mem, input logic [4:0] r, input logic [31:0] d, output int acc_cyc);
        bit acc = 1'b0;
        if (is_mem) begin MemValid = 1'b1; MemRegister = r; MemData = d; end
        else begin AluValid = 1'b1; AluRegister = r; AluData = d; end
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = is_mem ? MemReady : AluReady;
            @(posedge clk);
            #1;
        end
        acc_cyc = cyc;
        if (is_mem) MemValid = 1'b0; else AluValid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: offer reg %0d never accepted, expected acceptance", r);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int a, b, last7, n0, rel;
        bit seen12;
        // Reset state
        #1;
        chk("reset_WriteEnable", {31'd0, WriteEnable}, 32'd0);
        chk("reset_Empty", {31'd0, Empty}, 32'd1);
        chk("reset_MemReady", {31'd0, MemReady}, 32'd0);
        model_on = 1'b1;
        idle(2);
        ResetN = 1'b1;
        idle(1);

        // Single ALU write, latency check
        wlog.delete();
        send(1'b0, 5'd5, 32'hDEADBEEF, a);
        idle(5);
        chk("single_count", wlog.size(), 32'd1);
        if (wlog.size() >= 1) begin
            chk("single_reg", {27'd0, wlog[0].r}, 32'd5);
            chk("single_data", wlog[0].d, 32'hDEADBEEF);
            chk("single_latency", wlog[0].c - a + 1, EXP_LAT);
            chk("single_pend_during", {31'd0, wlog[0].p}, 32'd1);
        end
        chk("single_pend_after", Pending, 32'd0);

        // Simultaneous offers: load unit wins
        wlog.delete();
        AluValid = 1'b1; AluRegister = 5'd3; AluData = 32'h33;
        MemValid = 1'b1; MemRegister = 5'd4; MemData = 32'h44;
        @(negedge clk);
        chk("both_MemReady", {31'd0, MemReady}, 32'd1);
        chk("both_AluReady", {31'd0, AluReady}, 32'd0);
        @(posedge clk); #1;
        MemValid = 1'b0;
        send(1'b0, 5'd3, 32'h33, b);
        idle(5);
        chk("both_count", wlog.size(), 32'd2);
        if (wlog.size() >= 2) begin
            chk("both_first", {27'd0, wlog[0].r}, 32'd4);
            chk("both_second", {27'd0, wlog[1].r}, 32'd3);
        end

        // Register 0 is accepted and dropped
        wlog.delete();
        pend_seen = 1'b0;
        send(1'b0, 5'd0, 32'h1234, a);
        idle(5);
        chk("r0_writes", wlog.size(), 32'd0);
        chk("r0_pending_seen", {31'd0, pend_seen}, 32'd0);

        // Back-to-back load offers
        wlog.delete();
        for (int r = 1; r <= 5; r++) send(1'b1, 5'(r), 32'h100 + r, a);
        idle(8);
        chk("b2b_count", wlog.size(), 32'd5);
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            chk("b2b_order", {27'd0, wlog[i].r}, i + 1);
            chk("b2b_data", wlog[i].d, 32'h101 + i);
        end
        chk("b2b_Empty", {31'd0, Empty}, 32'd1);

        // Reset mid-stream
        wlog.delete();
        send(1'b1, 5'd10, 32'hA, a);
        send(1'b1, 5'd11, 32'hB, a);
        send(1'b1, 5'd12, 32'hC, a);
        MemValid = 1'b1; AluValid = 1'b1;
        ResetN = 1'b0;
        #1;
        chk("mid_rst_WriteEnable", {31'd0, WriteEnable}, 32'd0);
        chk("mid_rst_WriteRegister", {27'd0, WriteRegister}, 32'd0);
        chk("mid_rst_WriteData", WriteData, 32'd0);
        chk("mid_rst_Pending", Pending, 32'd0);
        chk("mid_rst_Empty", {31'd0, Empty}, 32'd1);
        chk("mid_rst_Full", {31'd0, Full}, 32'd0);
        chk("mid_rst_AluReady", {31'd0, AluReady}, 32'd0);
        chk("mid_rst_MemReady", {31'd0, MemReady}, 32'd0);
        n0 = wlog.size();
        MemValid = 1'b0; AluValid = 1'b0;
        idle(2);
        ResetN = 1'b1;
        rel = cyc;
        idle(8);
        chk("mid_rst_no_new_writes", wlog.size(), n0);
        seen12 = 1'b0;
        foreach (wlog[i]) if (wlog[i].r == 5'd12) seen12 = 1'b1;
        chk("mid_rst_reg12_never", {31'd0, seen12}, 32'd0);

        // Acceptance on the first edge after reset release
        ResetN = 1'b0;
        idle(1);
        ResetN = 1'b1;
        rel = cyc;
        send(1'b1, 5'd9, 32'h99, a);
        chk("post_rst_accept_cycle", a, rel + 1);
        idle(4);

        // Same-register ordering
        wlog.delete();
        send(1'b0, 5'd7, 32'h1, a);
        send(1'b0, 5'd7, 32'h2, a);
        idle(6);
        last7 = -1;
        foreach (wlog[i]) if (wlog[i].r == 5'd7) last7 = i;
        chk("r7_found", {31'd0, last7 >= 0}, 32'd1);
        if (last7 >= 0) begin
            chk("r7_last_data", wlog[last7].d, 32'h2);
            chk("r7_pend_during_last", {31'd0, wlog[last7].p}, 32'd1);
        end
        chk("r7_pend_after", {31'd0, Pending[7]}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            AluValid    = ($urandom_range(0, 1) == 1);
            MemValid    = ($urandom_range(0, 2) == 0);
            AluRegister = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            MemRegister = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            AluData     = $urandom;
            MemData     = $urandom;
            ResetN      = ($urandom_range(0, 99) != 0);
            idle(1);
        end
        ResetN = 1'b1; AluValid = 1'b0; MemValid = 1'b0;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
